// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI field widths, channel payload structs and traffic generator state type
package axi_pkg;

  localparam int AXI_ID_W          = 8;
  localparam int AXI_ADDR_W        = 32;
  localparam int AXI_DATA_W        = 64;
  localparam int MEM_WORDS_PER_CPU = 1024;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
  } axi_aw_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
  } axi_ar_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [1:0]            resp;
    logic [AXI_DATA_W-1:0] data;
  } axi_r_t;

  typedef enum logic [2:0] {
    TG_IDLE,
    TG_WR,
    TG_WB,
    TG_RD,
    TG_RR,
    TG_DONE
  } tg_state_e;

endpackage

// File: rtl/axi_traffic_gen.sv
// rtl/axi_traffic_gen.sv - per-CPU write/read-back AXI traffic generator with response checking
module axi_traffic_gen
  import axi_pkg::*;
#(
  parameter int CPU_IDX        = 0,
  parameter int TRANSACTION_NB = 1000,
  parameter int TIMEOUT        = 256
) (
  input  logic    clk,
  input  logic    rst_n,
  output axi_aw_t o_axi_m_aw,
  output logic    o_axi_m_awvalid,
  input  logic    i_axi_m_awready,
  output axi_w_t  o_axi_m_w,
  output logic    o_axi_m_wvalid,
  input  logic    i_axi_m_wready,
  input  axi_b_t  i_axi_m_b,
  input  logic    i_axi_m_bvalid,
  output logic    o_axi_m_bready,
  output axi_ar_t o_axi_m_ar,
  output logic    o_axi_m_arvalid,
  input  logic    i_axi_m_arready,
  input  axi_r_t  i_axi_m_r,
  input  logic    i_axi_m_rvalid,
  output logic    o_axi_m_rready,
  output logic    o_done,
  output logic [31:0] o_err_cnt,
  output logic    o_timeout
);

  localparam int          SLOT_W    = $clog2(MEM_WORDS_PER_CPU);
  localparam logic [31:0] LAST_SEQ  = 32'(TRANSACTION_NB - 1);
  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT - 1);

  // Word address inside this CPU's private window; the slot wraps so later pairs reuse it.
  function automatic logic [AXI_ADDR_W-1:0] seq_addr(input logic [31:0] s);
    logic [AXI_ADDR_W-1:0] word;
    word = AXI_ADDR_W'(CPU_IDX * MEM_WORDS_PER_CPU) + AXI_ADDR_W'(s[SLOT_W-1:0]);
    return word << 3;
  endfunction

  function automatic logic [AXI_DATA_W-1:0] seq_data(input logic [31:0] s);
    return {16'(CPU_IDX), 48'(s)};
  endfunction

  function automatic logic [AXI_ID_W-1:0] seq_id(input logic [31:0] s);
    return s[AXI_ID_W-1:0];
  endfunction

  tg_state_e   state_q, state_d;
  logic [31:0] seq_q, seq_d, seq_nxt;
  logic [31:0] wdog_q, wdog_d;
  logic [31:0] err_q, err_d;
  logic [32:0] err_sum;
  logic [2:0]  err_inc;
  axi_aw_t     aw_q, aw_d;
  axi_w_t      w_q, w_d;
  axi_ar_t     ar_q, ar_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic        bready_q, bready_d, rready_q, rready_d;
  logic        done_q, done_d, timeout_q, timeout_d;

  assign seq_nxt = seq_q + 32'd1;

  // State, sequence and every output are registered together so outputs never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TG_IDLE;
      seq_q     <= '0;
      wdog_q    <= '0;
      err_q     <= '0;
      aw_q      <= '0;
      w_q       <= '0;
      ar_q      <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      wdog_q    <= wdog_d;
      err_q     <= err_d;
      aw_q      <= aw_d;
      w_q       <= w_d;
      ar_q      <= ar_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, next-output and response checking for the write/read-back sequence.
  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    wdog_d    = wdog_q;
    aw_d      = aw_q;
    w_d       = w_q;
    ar_d      = ar_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    timeout_d = timeout_q;
    err_inc   = 3'd0;

    case (state_q)
      TG_IDLE: begin
        state_d   = TG_WR;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        aw_d      = '{id: seq_id(seq_q), addr: seq_addr(seq_q)};
        w_d       = '{data: seq_data(seq_q)};
      end
      TG_WR: begin
        // AW and W retire independently; move on once both have been accepted.
        if (awvalid_q && i_axi_m_awready) awvalid_d = 1'b0;
        if (wvalid_q && i_axi_m_wready) wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d = TG_WB;
          wdog_d  = '0;
        end
      end
      TG_WB: begin
        if (i_axi_m_bvalid) begin
          if (i_axi_m_b.id != seq_id(seq_q)) err_inc = err_inc + 3'd1;
          if (i_axi_m_b.resp != 2'd0) err_inc = err_inc + 3'd1;
          state_d   = TG_RD;
          arvalid_d = 1'b1;
          ar_d      = '{id: seq_id(seq_q), addr: seq_addr(seq_q)};
        end else if (wdog_q == WDOG_LAST) begin
          state_d   = TG_DONE;
          timeout_d = 1'b1;
          err_inc   = err_inc + 3'd1;
        end else begin
          wdog_d = wdog_q + 32'd1;
        end
      end
      TG_RD: begin
        if (i_axi_m_arready) begin
          arvalid_d = 1'b0;
          state_d   = TG_RR;
          wdog_d    = '0;
        end
      end
      TG_RR: begin
        if (i_axi_m_rvalid) begin
          if (i_axi_m_r.id != seq_id(seq_q)) err_inc = err_inc + 3'd1;
          if (i_axi_m_r.resp != 2'd0) err_inc = err_inc + 3'd1;
          if (i_axi_m_r.data != seq_data(seq_q)) err_inc = err_inc + 3'd1;
          if (seq_q == LAST_SEQ) begin
            state_d = TG_DONE;
          end else begin
            seq_d     = seq_nxt;
            state_d   = TG_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_d      = '{id: seq_id(seq_nxt), addr: seq_addr(seq_nxt)};
            w_d       = '{data: seq_data(seq_nxt)};
          end
        end else if (wdog_q == WDOG_LAST) begin
          state_d   = TG_DONE;
          timeout_d = 1'b1;
          err_inc   = err_inc + 3'd1;
        end else begin
          wdog_d = wdog_q + 32'd1;
        end
      end
      default: ;
    endcase

    // A response arriving while none is awaited is counted and dropped.
    if (i_axi_m_bvalid && state_q != TG_WB) err_inc = err_inc + 3'd1;
    if (i_axi_m_rvalid && state_q != TG_RR) err_inc = err_inc + 3'd1;

    err_sum  = {1'b0, err_q} + 33'(err_inc);
    err_d    = err_sum[32] ? '1 : err_sum[31:0];
    bready_d = (state_d != TG_IDLE) && (state_d != TG_DONE);
    rready_d = bready_d;
    done_d   = (state_d == TG_DONE);
  end

  assign o_axi_m_aw      = aw_q;
  assign o_axi_m_awvalid = awvalid_q;
  assign o_axi_m_w       = w_q;
  assign o_axi_m_wvalid  = wvalid_q;
  assign o_axi_m_bready  = bready_q;
  assign o_axi_m_ar      = ar_q;
  assign o_axi_m_arvalid = arvalid_q;
  assign o_axi_m_rready  = rready_q;
  assign o_done          = done_q;
  assign o_err_cnt       = err_q;
  assign o_timeout       = timeout_q;

endmodule

// File: tb/tb_axi_traffic_gen.sv
// tb/tb_axi_traffic_gen.sv - scoreboard bench for axi_traffic_gen with a randomized memory responder
module tb_axi_traffic_gen;
  import axi_pkg::*;

  localparam int CPU = 2;
  localparam int NB  = 1026;
  localparam int TMO = 16;

  logic        clk, rst_n;
  axi_aw_t     o_axi_m_aw;
  logic        o_axi_m_awvalid, i_axi_m_awready;
  axi_w_t      o_axi_m_w;
  logic        o_axi_m_wvalid, i_axi_m_wready;
  axi_b_t      i_axi_m_b;
  logic        i_axi_m_bvalid, o_axi_m_bready;
  axi_ar_t     o_axi_m_ar;
  logic        o_axi_m_arvalid, i_axi_m_arready;
  axi_r_t      i_axi_m_r;
  logic        i_axi_m_rvalid, o_axi_m_rready;
  logic        o_done, o_timeout;
  logic [31:0] o_err_cnt;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  id;
  } req_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  req_t        exp_aw[$];
  req_t        exp_ar[$];
  logic [63:0] exp_w[$];
  logic [63:0] mem [logic [31:0]];

  int mode = 0;
  bit lag_first = 0;
  int corrupt_pair = -1;
  bit drop_r = 0;
  bit timing_check = 0;
  int n_aw = 0, n_w = 0, n_ar = 0, n_r = 0, n_b = 0;
  int ar_hs_cyc = 0;
  logic [31:0] last_aw_addr = '0;

  axi_traffic_gen #(.CPU_IDX(CPU), .TRANSACTION_NB(NB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_axi_m_aw(o_axi_m_aw), .o_axi_m_awvalid(o_axi_m_awvalid), .i_axi_m_awready(i_axi_m_awready),
    .o_axi_m_w(o_axi_m_w), .o_axi_m_wvalid(o_axi_m_wvalid), .i_axi_m_wready(i_axi_m_wready),
    .i_axi_m_b(i_axi_m_b), .i_axi_m_bvalid(i_axi_m_bvalid), .o_axi_m_bready(o_axi_m_bready),
    .o_axi_m_ar(o_axi_m_ar), .o_axi_m_arvalid(o_axi_m_arvalid), .i_axi_m_arready(i_axi_m_arready),
    .i_axi_m_r(i_axi_m_r), .i_axi_m_rvalid(i_axi_m_rvalid), .o_axi_m_rready(o_axi_m_rready),
    .o_done(o_done), .o_err_cnt(o_err_cnt), .o_timeout(o_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising edges seen since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_addr(input int s);
    return 32'((CPU * 1024 + s % 1024) * 8);
  endfunction

  function automatic logic [63:0] ref_data(input int s);
    return (64'(CPU) << 48) | 64'(s);
  endfunction

  function automatic logic [7:0] ref_id(input int s);
    return 8'(s % 256);
  endfunction

  function automatic int resp_delay();
    return (mode == 0) ? 1 : 1 + int'($urandom_range(0, 3));
  endfunction

  // Memory responder: handshakes from the previous cycle are retired, then new readies are chosen.
  initial begin : responder
    bit aw_acc, w_acc, s_awv, s_wv, s_arv;
    axi_aw_t s_aw;
    axi_w_t s_w;
    axi_ar_t s_ar;
    logic [31:0] h_addr, r_addr;
    logic [7:0] h_id, b_id_q, r_id_q;
    logic [63:0] h_data, d;
    int b_cnt, r_cnt, lag_cnt, n_wr, n_rd;
    i_axi_m_awready = 0; i_axi_m_wready = 0; i_axi_m_arready = 0;
    i_axi_m_bvalid = 0; i_axi_m_rvalid = 0; i_axi_m_b = '0; i_axi_m_r = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_acc = 0; w_acc = 0; s_awv = 0; s_wv = 0; s_arv = 0;
        b_cnt = 0; r_cnt = 0; lag_cnt = 0; n_wr = 0; n_rd = 0;
        i_axi_m_awready = 0; i_axi_m_wready = 0; i_axi_m_arready = 0;
        i_axi_m_bvalid = 0; i_axi_m_rvalid = 0;
        continue;
      end
      i_axi_m_bvalid = 0;
      i_axi_m_rvalid = 0;
      if (b_cnt > 0) begin
        b_cnt--;
        if (b_cnt == 0) begin
          i_axi_m_bvalid = 1;
          i_axi_m_b = '{id: b_id_q, resp: 2'd0};
          n_b++;
        end
      end
      if (r_cnt > 0) begin
        r_cnt--;
        if (r_cnt == 0) begin
          d = mem.exists(r_addr) ? mem[r_addr] : 64'd0;
          if (n_rd == corrupt_pair) d[0] = ~d[0];
          i_axi_m_rvalid = 1;
          i_axi_m_r = '{id: r_id_q, resp: 2'd0, data: d};
          n_rd++;
        end
      end
      if (s_awv && i_axi_m_awready) begin
        aw_acc = 1; h_addr = s_aw.addr; h_id = s_aw.id; lag_cnt = 0;
      end
      if (s_wv && i_axi_m_wready) begin
        w_acc = 1; h_data = s_w.data;
      end
      if (aw_acc && w_acc) begin
        mem[h_addr] = h_data;
        b_id_q = h_id;
        b_cnt = resp_delay();
        aw_acc = 0; w_acc = 0;
        n_wr++;
      end
      if (s_arv && i_axi_m_arready) begin
        r_addr = s_ar.addr; r_id_q = s_ar.id;
        if (!drop_r) r_cnt = resp_delay();
      end
      if (aw_acc && !w_acc) lag_cnt++;
      s_awv = o_axi_m_awvalid; s_aw = o_axi_m_aw;
      s_wv  = o_axi_m_wvalid;  s_w  = o_axi_m_w;
      s_arv = o_axi_m_arvalid; s_ar = o_axi_m_ar;
      if (mode == 0) begin
        i_axi_m_awready = 1; i_axi_m_wready = 1; i_axi_m_arready = 1;
      end else begin
        i_axi_m_awready = 1'($urandom_range(0, 1));
        i_axi_m_wready  = 1'($urandom_range(0, 1));
        i_axi_m_arready = 1'($urandom_range(0, 1));
      end
      if (lag_first && n_wr == 0) begin
        i_axi_m_awready = 1;
        i_axi_m_wready  = aw_acc && (lag_cnt >= 3);
      end
    end
  end

  // Monitor: samples between edges, pops the expected request on every handshake.
  initial begin : monitor
    bit p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    axi_aw_t p_aw;
    axi_w_t p_w;
    axi_ar_t p_ar;
    req_t e;
    logic [63:0] ed;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        p_awv = 0; p_wv = 0; p_arv = 0;
        continue;
      end
      if (p_awv && !p_awr) begin
        chk("aw_valid_held", 64'(o_axi_m_awvalid), 64'd1);
        chk("aw_payload_held", {24'd0, o_axi_m_aw}, {24'd0, p_aw});
      end
      if (p_wv && !p_wr) begin
        chk("w_valid_held", 64'(o_axi_m_wvalid), 64'd1);
        chk("w_payload_held", o_axi_m_w.data, p_w.data);
      end
      if (p_arv && !p_arr) begin
        chk("ar_valid_held", 64'(o_axi_m_arvalid), 64'd1);
        chk("ar_payload_held", {24'd0, o_axi_m_ar}, {24'd0, p_ar});
      end
      if (o_axi_m_awvalid && i_axi_m_awready) begin
        if (exp_aw.size() == 0) begin
          checks++; errors++;
          $display("FAIL aw_extra: unexpected AW addr 0x%0h", o_axi_m_aw.addr);
        end else begin
          e = exp_aw.pop_front();
          chk("aw_addr", 64'(o_axi_m_aw.addr), 64'(e.addr));
          chk("aw_id", 64'(o_axi_m_aw.id), 64'(e.id));
        end
        last_aw_addr = o_axi_m_aw.addr;
        n_aw++;
      end
      if (o_axi_m_wvalid && i_axi_m_wready) begin
        if (exp_w.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_extra: unexpected W data 0x%0h", o_axi_m_w.data);
        end else begin
          ed = exp_w.pop_front();
          chk("w_data", o_axi_m_w.data, ed);
        end
        if (lag_first && n_w == 0) chk("aw_dropped_before_w", 64'(o_axi_m_awvalid), 64'd0);
        n_w++;
      end
      if (o_axi_m_arvalid && i_axi_m_arready) begin
        if (exp_ar.size() == 0) begin
          checks++; errors++;
          $display("FAIL ar_extra: unexpected AR addr 0x%0h", o_axi_m_ar.addr);
        end else begin
          e = exp_ar.pop_front();
          chk("ar_addr", 64'(o_axi_m_ar.addr), 64'(e.addr));
          chk("ar_id", 64'(o_axi_m_ar.id), 64'(e.id));
        end
        ar_hs_cyc = cyc;
        n_ar++;
      end
      if (o_axi_m_rready && i_axi_m_rvalid) begin
        n_r++;
        if (timing_check && n_r == 4) chk("pair4_r_cycle", 64'(cyc), 64'd24);
      end
      p_awv = o_axi_m_awvalid; p_awr = i_axi_m_awready; p_aw = o_axi_m_aw;
      p_wv  = o_axi_m_wvalid;  p_wr  = i_axi_m_wready;  p_w  = o_axi_m_w;
      p_arv = o_axi_m_arvalid; p_arr = i_axi_m_arready; p_ar = o_axi_m_ar;
    end
  end

  task automatic load_expected();
    exp_aw.delete(); exp_ar.delete(); exp_w.delete();
    for (int s = 0; s < NB; s++) begin
      exp_aw.push_back('{addr: ref_addr(s), id: ref_id(s)});
      exp_ar.push_back('{addr: ref_addr(s), id: ref_id(s)});
      exp_w.push_back(ref_data(s));
    end
    n_aw = 0; n_w = 0; n_ar = 0; n_r = 0; n_b = 0;
  endtask

  task automatic check_reset_vals();
    chk("rst_awvalid", 64'(o_axi_m_awvalid), 64'd0);
    chk("rst_wvalid", 64'(o_axi_m_wvalid), 64'd0);
    chk("rst_arvalid", 64'(o_axi_m_arvalid), 64'd0);
    chk("rst_bready", 64'(o_axi_m_bready), 64'd0);
    chk("rst_rready", 64'(o_axi_m_rready), 64'd0);
    chk("rst_aw", {24'd0, o_axi_m_aw}, 64'd0);
    chk("rst_w", o_axi_m_w.data, 64'd0);
    chk("rst_ar", {24'd0, o_axi_m_ar}, 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_err_cnt", 64'(o_err_cnt), 64'd0);
    chk("rst_timeout", 64'(o_timeout), 64'd0);
  endtask

  task automatic begin_phase(input int md, input bit lag, input int corr, input bit drop, input bit tchk);
    @(negedge clk);
    rst_n = 0;
    mode = md; lag_first = lag; corrupt_pair = corr; drop_r = drop; timing_check = tchk;
    load_expected();
    @(negedge clk);
    #2;
    check_reset_vals();
    @(negedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic wait_done(input int limit, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #2;
      if (o_done) begin
        at_cyc = cyc;
        break;
      end
    end
    chk("done_within_budget", 64'(at_cyc >= 0), 64'd1);
  endtask

  task automatic wait_count(input string nm, input int which, input int target, input int limit);
    int got;
    got = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #2;
      got = (which == 0) ? n_aw : n_ar;
      if (got >= target) break;
    end
    chk(nm, 64'(got >= target), 64'd1);
  endtask

  task automatic end_checks(input int exp_err);
    chk("end_err_cnt", 64'(o_err_cnt), 64'(exp_err));
    chk("end_timeout", 64'(o_timeout), 64'd0);
    chk("end_aw_count", 64'(n_aw), 64'(NB));
    chk("end_w_count", 64'(n_w), 64'(NB));
    chk("end_ar_count", 64'(n_ar), 64'(NB));
    chk("end_r_count", 64'(n_r), 64'(NB));
    chk("end_b_count", 64'(n_b), 64'(NB));
    chk("end_ready_low", 64'({o_axi_m_bready, o_axi_m_rready}), 64'd0);
  endtask

  initial begin : control
    int t;
    rst_n = 0;

    // Always-ready memory: exact pair latency, full run across the slot wrap.
    begin_phase(0, 0, -1, 0, 1);
    wait_done(8000, t);
    chk("p1_done_cycle", 64'(t), 64'(6 * NB + 1));
    end_checks(0);

    // Random readies and response delays; W lags AW on the first pair; R data of pair 1 corrupted.
    begin_phase(1, 1, 1, 0, 0);
    wait_done(30000, t);
    end_checks(1);

    // R never returned: watchdog expiry 16 cycles after the AR handshake.
    begin_phase(0, 0, -1, 1, 0);
    wait_count("p3_ar_seen", 1, 1, 100);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (cyc >= ar_hs_cyc + 16) break;
    end
    chk("p3_done_not_early", 64'(o_done), 64'd0);
    @(negedge clk);
    #2;
    chk("p3_done", 64'(o_done), 64'd1);
    chk("p3_timeout", 64'(o_timeout), 64'd1);
    chk("p3_err_cnt", 64'(o_err_cnt), 64'd1);
    chk("p3_ready_low", 64'({o_axi_m_bready, o_axi_m_rready}), 64'd0);

    // Reset asserted mid read response of pair 2, then a clean restart from seq 0.
    begin_phase(0, 0, -1, 0, 0);
    wait_count("p4_third_ar", 1, 3, 100);
    @(negedge clk);
    #3;
    rst_n = 0;
    #1;
    check_reset_vals();
    @(negedge clk);
    load_expected();
    #1;
    rst_n = 1;
    wait_count("p4_restart_aw", 0, 1, 20);
    chk("p4_restart_addr", 64'(last_aw_addr), 64'h4000);
    wait_done(8000, t);
    chk("p4_err_cnt", 64'(o_err_cnt), 64'd0);
    chk("p4_r_count", 64'(n_r), 64'(NB));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
